hazard_ctrl: RTL

- Central pipeline sequencer for the RV32I 5-stage core.
- Detects load-use hazards between ID and EX, and control-flow redirects (taken branch, jal, jalr).
- Drives hold/flush/bubble controls to PC, IF/ID and ID/EX registers.
- Replaces the ad-hoc flush flags kept inside individual pipe registers with one FSM owning all stall/flush sequencing.

---
 rtl/hazard_ctrl_if.sv | 30 +++
 rtl/hazard_ctrl.sv | 113 +++++++++++
 2 files changed

// File: rtl/hazard_ctrl_if.sv
// Hazard-control bundle: ID/EX operand info and redirect in, pipeline hold/flush controls out.
// The slave side is the sequencer; the master side is the pipeline datapath.
interface hazard_ctrl_if #(
  parameter int unsigned REG_AW = 5
);
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_use_rs1;
  logic              id_use_rs2;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_is_load;
  logic              redirect;
  logic              pc_hold;
  logic              ifid_hold;
  logic              ifid_flush;
  logic              idex_bubble;
  logic              busy;
  logic [31:0]       stall_cnt;
  logic [31:0]       flush_cnt;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_is_load, redirect,
    input  pc_hold, ifid_hold, ifid_flush, idex_bubble, busy, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_is_load, redirect,
    output pc_hold, ifid_hold, ifid_flush, idex_bubble, busy, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer owning all load-use stall and redirect flush sequencing (Mealy outputs).
// Optional perf counters stall_cnt/flush_cnt are built only when HAZARD_PERF_EN is defined.
module hazard_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned REG_AW       = 5
) (
  input logic           clk,
  input logic           rst,
  hazard_ctrl_if.slave  hz_io
);

  typedef enum logic [1:0] {StRun, StLstall, StFlush} state_e;

  // fcnt counts remaining FLUSH-state cycles after the one it is loaded for
  localparam logic [1:0] FcntInit = (FLUSH_CYCLES >= 2) ? 2'(FLUSH_CYCLES - 2) : 2'd0;

  state_e     state_q, state_d;
  logic [1:0] fcnt_q, fcnt_d;
  logic       lu;
  logic       pc_hold, ifid_hold, ifid_flush, idex_bubble;

  assign lu = hz_io.ex_is_load && (hz_io.ex_rd != '0) &&
              ((hz_io.id_use_rs1 && (hz_io.id_rs1 == hz_io.ex_rd)) ||
               (hz_io.id_use_rs2 && (hz_io.id_rs2 == hz_io.ex_rd)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StRun;
      fcnt_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    fcnt_d      = fcnt_q;
    pc_hold     = 1'b0;
    ifid_hold   = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    case (state_q)
      StRun, StLstall: begin
        if (hz_io.redirect) begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_d = StFlush;
            fcnt_d  = FcntInit;
          end else begin
            state_d = StRun;
          end
        end else if ((state_q == StRun) && lu) begin
          // EX holds a bubble during LSTALL, so lu is not re-evaluated there
          pc_hold     = 1'b1;
          ifid_hold   = 1'b1;
          idex_bubble = 1'b1;
          state_d     = StLstall;
        end else begin
          state_d = StRun;
        end
      end
      StFlush: begin
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
        if (hz_io.redirect) begin
          fcnt_d = FcntInit;
        end else if (fcnt_q == 2'd0) begin
          state_d = StRun;
        end else begin
          fcnt_d = fcnt_q - 2'd1;
        end
      end
      default: begin
        state_d = StRun;
        fcnt_d  = 2'd0;
      end
    endcase
  end

  // Outputs are combinational from inputs, so they must be forced low while reset is held
  assign hz_io.pc_hold     = pc_hold     & ~rst;
  assign hz_io.ifid_hold   = ifid_hold   & ~rst;
  assign hz_io.ifid_flush  = ifid_flush  & ~rst;
  assign hz_io.idex_bubble = idex_bubble & ~rst;
  assign hz_io.busy        = (state_q != StRun) & ~rst;

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      if (pc_hold) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (hz_io.redirect) begin
        flush_cnt_q <= flush_cnt_q + 32'd1;
      end
    end
  end

  assign hz_io.stall_cnt = stall_cnt_q;
  assign hz_io.flush_cnt = flush_cnt_q;
`else
  assign hz_io.stall_cnt = 32'd0;
  assign hz_io.flush_cnt = 32'd0;
`endif

endmodule
